// File: rtl/phys_free_list_pkg.sv
// Shared rename-path definitions: register counts, tag type, free-list sizing.
package phys_free_list_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int TAG_W         = $clog2(NUM_PHYS_REGS);
  localparam int FL_SZ         = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W         = $clog2(FL_SZ);
  localparam int CNT_W         = $clog2(FL_SZ + 1);

  typedef logic [TAG_W-1:0] tag_t;

  // Free-list slot i holds tag NUM_ARCH_REGS+i out of reset; tags 0..NUM_ARCH_REGS-1
  // start out as the committed architectural mappings.
  function automatic tag_t reset_tag(input int idx);
    return tag_t'(NUM_ARCH_REGS + idx);
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags. Dispatch pops from head,
// retire pushes Told at tail. arch_head trails head by the number of
// speculative (not yet retired) allocations, so a flush rewinds head to it.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dispatch_en,
  input  logic              retire_en,
  input  logic [TAG_W-1:0]  retire_told,
  input  logic              flush,
  output logic [TAG_W-1:0]  free_tag,
  output logic              free_valid,
  output logic              dispatch_gnt,
  output logic [CNT_W-1:0]  free_count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FL_SZ);

  logic [TAG_W-1:0] fl_q [FL_SZ];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;

  // Zero-latency lookahead outputs and next-state pointer/count arithmetic.
  always_comb begin
    free_valid   = (count_q != '0);
    dispatch_gnt = dispatch_en & free_valid & ~flush;
    free_tag     = fl_q[head_q];
    free_count   = count_q;

    // A push into a full list cannot happen in a legal machine; drop it so
    // the pointers stay consistent.
    push         = retire_en & (count_q != CNT_FULL);

    tail_d       = tail_q + PTR_W'(push);
    arch_head_d  = arch_head_q + PTR_W'(push);

    if (flush) begin
      // Every speculative allocation returns in one cycle: head rewinds to
      // the oldest unretired allocation, including a same-cycle retire.
      head_d  = arch_head_d;
      count_d = CNT_FULL;
    end else begin
      head_d  = head_q + PTR_W'(dispatch_gnt);
      count_d = count_q + CNT_W'(push) - CNT_W'(dispatch_gnt);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      arch_head_q <= '0;
      count_q     <= CNT_FULL;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      arch_head_q <= arch_head_d;
      count_q     <= count_d;
    end
  end

  // Tag storage: reset loads the initially unmapped tags, retire writes Told at tail.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_SZ; i++) fl_q[i] <= reset_tag(i);
    end else if (push) begin
      fl_q[tail_q] <= retire_told;
    end
  end

  // Retiring into a full list means a tag was duplicated somewhere upstream.
  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (!reset_n) !(retire_en && count_q == CNT_FULL));

endmodule
